// File: rtl/ones_pkg.sv
// ============================================================================
// Module  : ones_pkg
// Brief   : Shared state type and count-width helper for ones_expand.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ones_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold any count from 0 to w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ones_expand_fsm.sv
// ============================================================================
// Module  : ones_expand_fsm
// Brief   : IDLE/FILL/DONE control for ones_expand; active-low datapath strobes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ones_expand_fsm
  import ones_pkg::*;
(
  input  logic clock,
  input  logic reset_L,
  input  logic cnt_ready,
  input  logic range_bad,
  input  logic last,
  output logic load_n,
  output logic shift_n,
  output logic clear_n,
  output logic busy,
  output logic word_ready
);

  state_t state_q;
  logic   busy_q;
  logic   word_ready_q;
  logic   shift_q;
  logic   accept;

  assign accept = (state_q == IDLE) && cnt_ready;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      word_ready_q <= 1'b0;
      shift_q      <= 1'b0;
    end else begin
      word_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cnt_ready) begin
            busy_q <= 1'b1;
            // An out-of-range request skips the fill entirely.
            if (range_bad) begin
              state_q      <= DONE;
              word_ready_q <= 1'b1;
            end else begin
              state_q <= FILL;
              shift_q <= 1'b1;
            end
          end
        end
        FILL: begin
          if (last) begin
            state_q      <= DONE;
            shift_q      <= 1'b0;
            word_ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          shift_q <= 1'b0;
        end
      endcase
    end
  end

  assign load_n     = ~(accept && !range_bad);
  assign clear_n    = ~accept;
  assign shift_n    = ~shift_q;
  assign busy       = busy_q;
  assign word_ready = word_ready_q;

endmodule

`default_nettype wire

// File: rtl/ones_expand.sv
// ============================================================================
// Module  : ones_expand
// Brief   : Serially builds a w-bit word with k ones at the LSB end, (1<<k)-1.
//           Macro ONES_EXPAND_SAT_EN clamps k > w to w instead of flagging err.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ones_expand
  import ones_pkg::*;
#(
  parameter  int w  = 30,
  localparam int CW = cnt_width(w)
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          cnt_ready,
  input  logic [CW-1:0] cnt_in,
  output logic          busy,
  output logic          word_ready,
  output logic [w-1:0]  word_out,
  output logic          err
);

  logic [w-1:0]  sr_q,  sr_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          err_q, err_d;

  logic          over;
  logic          range_bad;
  logic [CW-1:0] load_cnt;
  logic          last;
  logic          load_n;
  logic          shift_n;
  logic          clear_n;

  assign over = cnt_in > CW'(w);
  assign last = idx_q == CW'(w - 1);

`ifdef ONES_EXPAND_SAT_EN
  assign range_bad = 1'b0;
  assign load_cnt  = over ? CW'(w) : cnt_in;
`else
  assign range_bad = over;
  assign load_cnt  = cnt_in;
`endif

  ones_expand_fsm u_fsm (
    .clock      (clock),
    .reset_L    (reset_L),
    .cnt_ready  (cnt_ready),
    .range_bad  (range_bad),
    .last       (last),
    .load_n     (load_n),
    .shift_n    (shift_n),
    .clear_n    (clear_n),
    .busy       (busy),
    .word_ready (word_ready)
  );

  always_comb begin
    sr_d  = sr_q;
    rem_d = rem_q;
    idx_d = idx_q;
    err_d = err_q;
    if (!clear_n) begin
      sr_d  = '0;
      idx_d = '0;
      err_d = range_bad;
    end
    if (!load_n) begin
      rem_d = load_cnt;
    end else if (!shift_n) begin
      // Ones enter at the MSB first, so after w shifts they sit at the bottom.
      sr_d  = {rem_q != '0, sr_q[w-1:1]};
      idx_d = idx_q + CW'(1);
      if (rem_q != '0) rem_d = rem_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sr_q  <= '0;
      rem_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      rem_q <= rem_d;
      idx_q <= idx_d;
      err_q <= err_d;
    end
  end

  assign word_out = sr_q;
  assign err      = err_q & word_ready;

endmodule

`default_nettype wire

// File: tb/tb_ones_expand.sv
// ============================================================================
// Module  : tb_ones_expand
// Brief   : Randomized self-checking bench for ones_expand (w = 30).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ones_expand;

  localparam int W  = 30;
  localparam int CW = $clog2(W + 1);

  logic          clock;
  logic          reset_L;
  logic          cnt_ready;
  logic [CW-1:0] cnt_in;
  logic          busy;
  logic          word_ready;
  logic [W-1:0]  word_out;
  logic          err;

  int tests_run;
  int tests_failed;
  int starts;
  int ready_seen;

  ones_expand #(.w(W)) dut (
    .clock      (clock),
    .reset_L    (reset_L),
    .cnt_ready  (cnt_ready),
    .cnt_in     (cnt_in),
    .busy       (busy),
    .word_ready (word_ready),
    .word_out   (word_out),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (word_ready) ready_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: result, latency and err straight from the count rules.
  task automatic model(input int k, output logic [63:0] ew, output int lat, output logic eerr);
    int kk;
    kk = k;
    lat = W + 1;
    eerr = 1'b0;
    if (k > W) begin
`ifdef ONES_EXPAND_SAT_EN
      kk = W;
`else
      kk = 0;
      lat = 1;
      eerr = 1'b1;
`endif
    end
    ew = (64'd1 << kk) - 64'd1;
  endtask

  // Starts one request at the next negedge; returns at the negedge of the word_ready cycle.
  task automatic run(input int k, input int inject_at);
    logic [63:0] ew;
    int          lat;
    logic        eerr;
    int          n;
    bit          got;
    model(k, ew, lat, eerr);
    @(negedge clock);
    check("idle_busy", 64'(busy), 64'd0);
    cnt_ready = 1'b1;
    cnt_in    = CW'(k);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clock);
      n++;
      cnt_ready = (n == inject_at);
      cnt_in    = (n == inject_at) ? CW'(7) : cnt_in;
      if (word_ready) got = 1'b1;
      else if (busy !== 1'b1) check("busy_fill", 64'(busy), 64'd1);
    end
    cnt_ready = 1'b0;
    starts++;
    check("latency", 64'(n), 64'(lat));
    if (got) begin
      check("word", 64'(word_out), ew);
      check("popcount", 64'($countones(word_out)), 64'($countones(ew)));
      check("err", 64'(err), 64'(eerr));
      check("busy_done", 64'(busy), 64'd1);
    end
  endtask

  initial begin
    bit seen;
    tests_run    = 0;
    tests_failed = 0;
    starts       = 0;
    ready_seen   = 0;
    reset_L      = 1'b0;
    cnt_ready    = 1'b0;
    cnt_in       = '0;
    #23;
    check("rst_word", 64'(word_out), 64'd0);
    check("rst_ctl", 64'({busy, word_ready, err}), 64'd0);
    @(negedge clock);
    reset_L = 1'b1;

    run(5, -1);
    run(0, -1);
    run(30, -1);
    run(31, -1);
    run(3, 10);
    repeat (5) @(negedge clock);
    check("hold_word", 64'(word_out), 64'h7);
    check("hold_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a fill.
    @(negedge clock);
    cnt_ready = 1'b1;
    cnt_in    = CW'(9);
    @(negedge clock);
    cnt_ready = 1'b0;
    repeat (11) @(negedge clock);
    #2 reset_L = 1'b0;
    #1;
    check("mid_rst_word", 64'(word_out), 64'd0);
    check("mid_rst_ctl", 64'({busy, word_ready, err}), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_L = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (word_ready) seen = 1'b1;
    end
    check("no_ready_after_rst", 64'(seen), 64'd0);
    run(2, -1);

    for (int i = 0; i < 200; i++) run(int'($urandom_range(0, W)), -1);

    @(negedge clock);
    check("pulses", 64'(ready_seen), 64'(starts));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ones_expand.md
Name: ones_expand

Overview:
- Inverse of the team's serial ones-counter: takes a count k and serially builds a w-bit thermometer word with exactly k ones packed at the LSB end.
- Result is `word_out = (1<<k)-1`.
- Sits on the test/stimulus side of the datapath. It generates known-population words for the ones-count path and for mask generation.
- Iterative: one bit is inserted per clock for w clocks, under a small FSM with a start/done handshake.

Parameters:
- w, 30, width of the generated word (w >= 2).
- CW, $clog2(w+1), localparam: width of count input and internal counters (must represent w).

Ports:
- clock  input  1  system clock, rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- cnt_ready  input  1  start strobe; sampled only in IDLE.
- cnt_in  input  CW  requested number of ones k.
- busy  output  1  high whenever state != IDLE.
- word_ready  output  1  one-cycle pulse; word_out is the final result in that cycle.
- word_out  output  w  generated word; holds its value after DONE until the next accepted start.
- err  output  1  valid only with word_ready; flags an out-of-range count.

Behaviour:
- Reset: reset_L low forces the following immediately, regardless of clock, including mid-FILL:
  - state = IDLE
  - word_out = 0; busy, word_ready, err = 0
  - remaining counter and index counter = 0
- Datapath:
  - w-bit right-shift register drives word_out.
  - CW-bit down counter `rem` holds the ones still to insert.
  - CW-bit up counter `idx` counts shifts.
- FSM states IDLE, FILL, DONE.
- IDLE:
  - cnt_ready=0: stay in IDLE.
  - cnt_ready=1 and cnt_in <= w: at the edge, load rem=cnt_in, clear idx, clear shift reg, go to FILL.
  - cnt_ready=1 and cnt_in > w: handled per Optional Feature.
- FILL:
  - Each edge shifts right with serial-in at the MSB; serial-in = (rem != 0).
  - If rem != 0, rem decrements; idx increments.
  - On the edge where idx == w-1, go to DONE.
  - FILL lasts exactly w cycles for every k, including 0 and w.
- DONE: word_ready=1 for one cycle, err as defined below, then go to IDLE unconditionally.
- Latency: start accepted at the edge closing cycle t → FILL in cycles t+1..t+w → word_ready high in cycle t+w+1. Back-to-back starts: next accept possible in cycle t+w+2.
- cnt_ready in FILL or DONE is ignored; it is not queued.
- Bit order: ones inserted first travel to the low bits, so bits [k-1:0]=1 and the rest are 0. k=0 gives all zeros; k=w gives all ones.
- word_out during FILL shows partial shifts; consumers use it only at word_ready or later, while in IDLE.

Optional Feature:
- Macro: ONES_EXPAND_SAT_EN.
- Without it (strict):
  - cnt_in > w at accept skips FILL and goes IDLE→DONE at the next edge.
  - Shift register is cleared, so word_out = 0; err=1 with word_ready in cycle t+1.
  - In-range counts give err=0.
- With it:
  - cnt_in > w is clamped to w at load, then a normal w-cycle FILL runs.
  - Result is word_out all ones; err is tied 0.

Decomposition:
- Package ones_pkg contains:
  - typedef enum for state {IDLE, FILL, DONE}
  - a function that returns the count width for a given w
- Sub-module ones_expand_fsm: pure control. Inputs cnt_ready, range_bad, last (idx==w-1). Outputs the active-low load/shift/clear controls, busy, word_ready.
- Shift register, counters and comparators stay in ones_expand.

Test Plan:
- w=30, cnt_in=5, pulse cnt_ready at cycle 0 → word_ready only in cycle 31; word_out=0x0000001F; err=0; busy high in cycles 1-31.
- cnt_in=0 → word_out=0x00000000 at cycle 31. cnt_in=30 → word_out=0x3FFFFFFF at cycle 31.
- cnt_in=31, strict build → word_ready in cycle 1, err=1, word_out=0. Same stimulus with ONES_EXPAND_SAT_EN → word_ready in cycle 31, word_out=0x3FFFFFFF, err=0.
- cnt_in=3 accepted, then cnt_ready with cnt_in=7 at cycle 10 → ignored; result at cycle 31 is 0x00000007; word_out holds that value in IDLE until the next accept.
- reset_L low at cycle 12 of a fill, asynchronously mid-cycle → word_out, busy, word_ready, err = 0 immediately; no word_ready afterwards. New start after release with cnt_in=2 → 0x00000003 at w+1 cycles later.
- Random k in 0..30, 200 back-to-back runs → popcount(word_out)=k, word_out==(1<<k)-1, exactly one word_ready per accepted start.
